// File: rtl/mode_selector.sv
// mode_selector: debounced KEY0 press advances a wrapping operation-mode register.
// Optional MODE_SEL_AUTOREPEAT_EN: keep advancing every REPEAT_CYCLES while held.
module mode_selector #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int NUM_MODES       = 12,
    parameter int MODE_W          = 4,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_change_n,
    output logic [MODE_W-1:0] mode,
    output logic              mode_pulse,
    output logic              btn_level
);
    localparam int MAX_CYC = DEBOUNCE_CYCLES > REPEAT_CYCLES ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W = $clog2(MAX_CYC);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
`ifdef MODE_SEL_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic              pulse_q, pulse_d, level_q, level_d;
    logic              s1_q, s2_q, adv;
    logic              pressed_s;

    assign pressed_s  = ~s2_q;
    assign mode       = mode_q;
    assign mode_pulse = pulse_q;
    assign btn_level  = level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
        end else begin
            s1_q    <= btn_change_n;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            pulse_q <= pulse_d;
            level_q <= level_d;
        end
    end

    // Counter saturates by default; every transition clears it explicitly.
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        level_d = level_q;
        adv     = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pressed_s) state_d = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!pressed_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    adv     = 1'b1;
                end
            end
            HELD: begin
                if (!pressed_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
`ifdef MODE_SEL_AUTOREPEAT_EN
                else if (cnt_q == RP_LAST) begin
                    cnt_d = '0;
                    adv   = 1'b1;
                end
`else
                else cnt_d = '0;
`endif
            end
            RELEASE_WAIT: begin
                if (pressed_s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        pulse_d = adv;
        mode_d  = !adv ? mode_q : (mode_q == MODE_W'(NUM_MODES - 1)) ? '0 : mode_q + MODE_W'(1);
    end
endmodule

// File: tb/tb_mode_selector.sv
// tb_mode_selector: directed stimulus; run-length debounce model plus literal checks.
module tb_mode_selector;
    localparam int D  = 4;
    localparam int NM = 12;
    localparam int R  = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_change_n = 1'b1;
    logic [3:0] mode;
    logic       mode_pulse, btn_level;

    int checks = 0;
    int errors = 0;
    int npulse = 0;

    // Model state: synchronizer copy, run length of the synchronized level, outputs.
    logic b1 = 1'b1, b2 = 1'b1, ps, last_ps = 1'b0, lvl = 1'b0, mpulse = 1'b0, prev_pulse = 1'b0;
    int   run = 0, age = 0, mmode = 0;

    mode_selector #(.DEBOUNCE_CYCLES(D), .NUM_MODES(NM), .MODE_W(4), .REPEAT_CYCLES(R)) dut (
        .clk(clk), .rst(rst), .btn_change_n(btn_change_n),
        .mode(mode), .mode_pulse(mode_pulse), .btn_level(btn_level)
    );

    always #5 clk = ~clk;

    // A level is accepted once the synchronized pin has held it for D+1 consecutive edges.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                b1 = 1'b1; b2 = 1'b1; last_ps = 1'b0; run = 0;
                lvl = 1'b0; mmode = 0; mpulse = 1'b0; age = 0;
            end else begin
                ps = !b2;
                b2 = b1;
                b1 = btn_change_n;
                run = (ps == last_ps) ? run + 1 : 1;
                last_ps = ps;
                mpulse = 1'b0;
                if (ps != lvl && run == D + 1) begin
                    lvl = ps;
                    age = 0;
                    if (ps) begin
                        mmode = (mmode + 1) % NM;
                        mpulse = 1'b1;
                    end
                end
`ifdef MODE_SEL_AUTOREPEAT_EN
                else if (lvl && ps) begin
                    age = (run == 1) ? 0 : age + 1;
                    if (age == R) begin
                        age = 0;
                        mmode = (mmode + 1) % NM;
                        mpulse = 1'b1;
                    end
                end
`endif
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            checks++;
            if (mode !== 4'(mmode) || mode_pulse !== mpulse || btn_level !== lvl) begin
                errors++;
                $display("FAIL model t=%0t: mode=%0d pulse=%b level=%b, required mode=%0d pulse=%b level=%b",
                         $time, mode, mode_pulse, btn_level, mmode, mpulse, lvl);
            end
            checks++;
            if (mode_pulse === 1'b1 && prev_pulse) begin
                errors++;
                $display("FAIL pulse_back_to_back t=%0t: got two consecutive pulses, required single", $time);
            end
            prev_pulse = (mode_pulse === 1'b1);
            if (mode_pulse === 1'b1) npulse++;
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int lo, input int hi);
        btn_change_n = 1'b0;
        cyc(lo);
        btn_change_n = 1'b1;
        cyc(hi);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
    endtask

    initial begin
        int p0, lat;
        #2 rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(50);
        chk("idle_mode", int'(mode), 0);
        chk("idle_pulses", npulse, 0);
        chk("idle_level", int'(btn_level), 0);

        // Clean press: pulse visible 7 negedges after the pin falls at a negedge.
        p0 = npulse;
        lat = 0;
        btn_change_n = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (mode_pulse === 1'b1 && lat == 0) lat = i;
        end
        chk("press_level", int'(btn_level), 1);
        btn_change_n = 1'b1;
        cyc(20);
        chk("press_latency", lat, 7);
        chk("press_mode", int'(mode), 1);
        chk("press_pulses", npulse - p0, 1);
        chk("release_level", int'(btn_level), 0);

        // Bounce on press, then a short glitch.
        p0 = npulse;
        for (int i = 0; i < 5; i++) begin
            btn_change_n = i[0];
            cyc(1);
        end
        btn_change_n = 1'b0;
        cyc(20);
        btn_change_n = 1'b1;
        cyc(20);
        chk("bounce_pulses", npulse - p0, 1);
        chk("bounce_mode", int'(mode), 2);
        p0 = npulse;
        press(2, 20);
        chk("glitch_pulses", npulse - p0, 0);
        chk("glitch_mode", int'(mode), 2);

        // Wrap through all modes.
        do_reset();
        p0 = npulse;
        for (int i = 1; i <= NM; i++) begin
            press(10, 10);
            chk($sformatf("wrap_mode_%0d", i), int'(mode), i % NM);
        end
        chk("wrap_pulses", npulse - p0, NM);

        // Reset while PRESS_WAIT with mode 5, button still held afterwards.
        do_reset();
        for (int i = 0; i < 5; i++) press(10, 10);
        chk("pre_reset_mode", int'(mode), 5);
        btn_change_n = 1'b0;
        cyc(3);
        rst = 1'b1;
        cyc(2);
        chk("reset_mode", int'(mode), 0);
        chk("reset_level", int'(btn_level), 0);
        p0 = npulse;
        rst = 1'b0;
        cyc(15);
        chk("rearm_mode", int'(mode), 1);
        chk("rearm_pulses", npulse - p0, 1);
        btn_change_n = 1'b1;
        cyc(15);

        // Long hold: auto-repeat gives 4 advances, otherwise exactly one.
        do_reset();
        p0 = npulse;
        btn_change_n = 1'b0;
        cyc(60);
`ifdef MODE_SEL_AUTOREPEAT_EN
        chk("hold_mode", int'(mode), 4);
        chk("hold_pulses", npulse - p0, 4);
`else
        chk("hold_mode", int'(mode), 1);
        chk("hold_pulses", npulse - p0, 1);
`endif
        btn_change_n = 1'b1;
        cyc(20);
        chk("hold_release_level", int'(btn_level), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mode_selector.md
Name: mode_selector

Overview:
- Front-end stage directly upstream of the parameter calculator.
- Turns the raw, bouncing KEY0 push-button into one clean advance event per physical press.
- Holds the calculator's operation-mode register, range 0..NUM_MODES-1 with wrap-around.
- The calculator consumes `mode` (its operation select) and the one-cycle `mode_pulse`.

Parameters:
- DEBOUNCE_CYCLES, 500000: cycles the synchronized level must stay stable before a press or release is accepted (10 ms at 50 MHz). Must be ≥ 2.
- NUM_MODES, 12: number of operation modes; `mode` wraps from NUM_MODES-1 to 0.
- MODE_W, 4: width of `mode`; must satisfy 2^MODE_W ≥ NUM_MODES.
- REPEAT_CYCLES, 25000000: auto-repeat period while held. Used only with MODE_SEL_AUTOREPEAT_EN.

Ports:
- clk, input, 1: system clock, single domain.
- rst, input, 1: asynchronous, active-high reset.
- btn_change_n, input, 1: raw KEY0 level; active-low (0 = pressed), asynchronous to clk.
- mode, output, MODE_W: current operation mode, registered.
- mode_pulse, output, 1: high for exactly one cycle, in the same cycle `mode` first shows its new value.
- btn_level, output, 1: debounced button state, active-high (1 = pressed), registered.

Behaviour:
- Reset is asynchronous on rst rising and stays in force while rst = 1. Reset values:
  - mode = 0, mode_pulse = 0, btn_level = 0.
  - Both synchronizer flops = 1 (released).
  - Debounce counter = 0, FSM state = IDLE.
- Synchronizer: two flops on btn_change_n. `pressed_s` = inverted output of the second flop. No other logic reads the raw pin.
- Counter: width clog2 of the larger of DEBOUNCE_CYCLES and REPEAT_CYCLES. Cleared on every state transition. Saturates; it never wraps.
- FSM, evaluated every clk edge:
  - IDLE: if pressed_s = 1 → PRESS_WAIT, counter = 0.
  - PRESS_WAIT:
    - if pressed_s = 0 → IDLE. Glitch rejected, mode unchanged, no pulse.
    - else if counter = DEBOUNCE_CYCLES-1 → HELD. In the same edge: mode advances, mode_pulse = 1 for the next cycle, btn_level = 1.
    - else counter + 1.
  - HELD: if pressed_s = 0 → RELEASE_WAIT, counter = 0.
  - RELEASE_WAIT:
    - if pressed_s = 1 → HELD. Release bounce; no advance, no pulse.
    - else if counter = DEBOUNCE_CYCLES-1 → IDLE, btn_level = 0.
    - else counter + 1.
- Mode arithmetic: if mode = NUM_MODES-1 then next = 0, else mode + 1. Codes ≥ NUM_MODES never appear.
- Latency: pin held low continuously from cycle t gives mode_pulse in cycle t + 2 + DEBOUNCE_CYCLES (±1 for input sampling phase).
- A press shorter than DEBOUNCE_CYCLES synchronized cycles produces no pulse.
- One physical press gives exactly one pulse, regardless of bounce on press or release.
- mode_pulse is never high in two consecutive cycles.
- Reset mid-operation (any state): immediate return to reset values; any pending advance is discarded. A button still held when rst deasserts is treated as a new press: one advance, from mode 0 to 1, after debounce.
- rst deassertion is synchronized externally. This block does not add a reset synchronizer.

Optional Feature:
- Macro: MODE_SEL_AUTOREPEAT_EN.
- Defined:
  - In HELD the counter runs. At counter = REPEAT_CYCLES-1, mode advances with wrap, mode_pulse = 1 for one cycle, and the counter clears.
  - This repeats every REPEAT_CYCLES cycles while held.
  - Leaving HELD clears the counter.
- Not defined: HELD is a pure wait state and no repeat logic is synthesized.

Test Plan (DEBOUNCE_CYCLES = 4, NUM_MODES = 12, REPEAT_CYCLES = 16):
- Reset then idle: assert rst for 3 cycles, hold btn_change_n = 1 for 50 cycles → mode = 0, mode_pulse and btn_level stay 0 throughout.
- Clean press: drive btn_change_n = 0 for 20 cycles, then 1 → exactly one mode_pulse, about 6 cycles after the falling edge; mode = 1; btn_level returns to 0 about 6 cycles after release.
- Bounce and glitch: toggle btn_change_n every cycle 5 times, then hold 0 for 20 cycles. Separately, apply a 2-cycle low glitch → one pulse for the bounced press, none for the glitch; mode increments by exactly 1.
- Wrap: perform 12 clean presses from reset → mode sequence 1..11 then 0; 12 pulses total.
- Reset mid-press: assert rst while in PRESS_WAIT with mode = 5, keep the button low, release rst → mode = 0 immediately; one pulse after debounce gives mode = 1.
- Auto-repeat (macro defined): hold btn_change_n = 0 for 60 cycles → first pulse after debounce, then pulses 16 cycles apart; mode = 4 at release. Without the macro → mode = 1.
